result_monitor: RTL and testbench

RESULT_MONITOR -- requirements
Module: result_monitor

---
 rtl/result_monitor.sv | 195 +++++++++++++++++++
 tb/tb_result_monitor.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_monitor.sv
// Result history buffer with LED slice display and serial dump of the newest entry.
// Captures land in a DEPTH-deep ring; a synchronised dump_req edge shifts the newest word out MSB first.
module result_monitor #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned LED_W   = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned BIT_DIV = 4
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              in_valid,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic [$clog2(DEPTH)-1:0]          sel_entry,
  input  logic [$clog2(DATA_W/LED_W)-1:0]   sel_slice,
  input  logic                              dump_req,
  input  logic                              ovf_clr,
  output logic [LED_W-1:0]                  led,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              ovf,
  output logic                              tx_clk,
  output logic                              tx_data,
  output logic                              tx_busy
);

  localparam int unsigned NSLICE = DATA_W / LED_W;
  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned SW     = $clog2(NSLICE);
  localparam int unsigned BW     = $clog2(DATA_W);
  localparam int unsigned DW     = $clog2(BIT_DIV);
  localparam int unsigned HALF   = BIT_DIV / 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic              full;
  logic [PW-1:0]     rd_idx;
  logic [PW-1:0]     newest_idx;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_word;
  logic [LED_W-1:0]  led_nxt;

  logic              sync1;
  logic              sync2;
  logic              sync3;
  logic              dump_edge;

  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;
  logic              bit_end;

  // ---------------- capture side ----------------
  assign full = (count == CW'(DEPTH));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (in_valid) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (!full) begin
          count <= count + CW'(1);
        end
      end
      if (in_valid && full) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Storage needs no reset: count masks stale contents.
  always_ff @(posedge CLK) begin
    if (in_valid) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // ---------------- display side ----------------
  assign newest_idx = wr_ptr - PW'(1);
  assign rd_idx     = wr_ptr - PW'(1) - sel_entry;
  assign rd_hit     = ({1'b0, sel_entry} < count);
  assign rd_word    = rd_hit ? mem[rd_idx] : '0;

  always_comb begin
    led_nxt = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (SW'(i) == sel_slice) begin
        led_nxt = rd_word[i*LED_W +: LED_W];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      led <= '0;
    end else begin
      led <= led_nxt;
    end
  end

  // ---------------- dump request synchroniser ----------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= dump_req;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign dump_edge = sync2 & ~sync3;

  // ---------------- dump FSM ----------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign bit_end = (div_cnt == DW'(BIT_DIV - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dump_edge && (count != '0)) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (bit_end && (bit_cnt == '0)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_busy = 1'b0;
    tx_clk  = 1'b0;
    tx_data = 1'b0;
    case (state)
      LOAD: tx_busy = 1'b1;
      SHIFT: begin
        tx_busy = 1'b1;
        tx_clk  = (div_cnt >= DW'(HALF));
        tx_data = shreg[DATA_W-1];
      end
      DONE: tx_busy = 1'b1;
      default: ;
    endcase
  end

  // LOAD copies the pre-capture newest word, so a same-cycle capture never leaks into the dump.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          shreg   <= mem[newest_idx];
          bit_cnt <= BW'(DATA_W - 1);
          div_cnt <= '0;
        end
        SHIFT: begin
          if (bit_end) begin
            div_cnt <= '0;
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt - BW'(1);
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: div_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_result_monitor.sv
// Self-checking bench for result_monitor: directed scenarios plus randomized captures
// compared against a queue-based history model.
module tb_result_monitor;

  localparam int DATA_W  = 128;
  localparam int LED_W   = 16;
  localparam int DEPTH   = 4;
  localparam int BIT_DIV = 4;
  localparam int DUMP_CYCLES = 2 + DATA_W * BIT_DIV;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic [1:0]   sel_entry = '0;
  logic [2:0]   sel_slice = '0;
  logic         dump_req = 1'b0;
  logic         ovf_clr = 1'b0;
  logic [15:0]  led;
  logic [2:0]   count;
  logic         ovf;
  logic         tx_clk;
  logic         tx_data;
  logic         tx_busy;

  int errors = 0;
  int checks = 0;

  logic [127:0] hist[$];
  logic         m_ovf = 1'b0;

  always #5 CLK = ~CLK;

  result_monitor #(
    .DATA_W (DATA_W),
    .LED_W  (LED_W),
    .DEPTH  (DEPTH),
    .BIT_DIV(BIT_DIV)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .in_valid (in_valid),
    .in_data  (in_data),
    .sel_entry(sel_entry),
    .sel_slice(sel_slice),
    .dump_req (dump_req),
    .ovf_clr  (ovf_clr),
    .led      (led),
    .count    (count),
    .ovf      (ovf),
    .tx_clk   (tx_clk),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [127:0] m_entry(int k);
    return (k < hist.size()) ? hist[k] : 128'h0;
  endfunction

  function automatic logic [15:0] m_slice(int k, int s);
    logic [127:0] e;
    e = m_entry(k) >> (16 * s);
    return e[15:0];
  endfunction

  task automatic m_apply(input logic v, input logic [127:0] d, input logic clr);
    if (v && hist.size() == DEPTH) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (v) begin
      if (hist.size() == DEPTH) void'(hist.pop_back());
      hist.push_front(d);
    end
  endtask

  function automatic logic [127:0] mk_word(logic [3:0] tag);
    logic [127:0] w;
    for (int s = 0; s < 8; s++) w[16*s +: 16] = {tag, 8'h00, 4'(s)};
    return w;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input logic v, input logic [127:0] d, input logic clr);
    in_valid = v;
    in_data  = d;
    ovf_clr  = clr;
    tick();
    m_apply(v, d, clr);
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    dump_req = 1'b0;
    RESET    = 1'b0;
    #2;
    hist.delete();
    m_ovf = 1'b0;
    RESET = 1'b1;
    tick();
  endtask

  // Starts a dump and watches it until busy drops, sampling tx_data on tx_clk rises.
  task automatic run_dump(input int poke_at, input bit cap_in_load, input int abort_bits,
                          output bit started, output int busy_cycles, output int nbits,
                          output logic [127:0] word);
    logic prev;
    started = 1'b0;
    busy_cycles = 0;
    nbits = 0;
    word = '0;
    dump_req = 1'b1;
    for (int i = 0; i < 20 && !started; i++) begin
      tick();
      if (i == 2) dump_req = 1'b0;
      if (tx_busy === 1'b1) started = 1'b1;
    end
    dump_req = 1'b0;
    if (!started) return;
    busy_cycles = 1;
    prev = tx_clk;
    if (cap_in_load) begin
      in_valid = 1'b1;
      in_data  = {4{32'hFFFF_FFFF}};
    end
    for (int c = 1; c < 3000; c++) begin
      tick();
      if (c == 1 && cap_in_load) begin
        in_valid = 1'b0;
        m_apply(1'b1, {4{32'hFFFF_FFFF}}, 1'b0);
      end
      if (c == poke_at) dump_req = 1'b1;
      if (c == poke_at + 3) dump_req = 1'b0;
      if (tx_busy !== 1'b1) break;
      busy_cycles++;
      if (tx_clk === 1'b1 && prev === 1'b0) begin
        word = {word[126:0], tx_data};
        nbits++;
      end
      prev = tx_clk;
      if (nbits == abort_bits) return;
    end
    dump_req = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if ({led, count, ovf, tx_clk, tx_data, tx_busy} !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: got led=%h count=%0d ovf=%b txc=%b txd=%b busy=%b, expected all 0",
               led, count, ovf, tx_clk, tx_data, tx_busy);
    end
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_capture_basic();
    do_reset();
    sel_entry = 2'd0;
    sel_slice = 3'd0;
    step(1'b1, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
    checks++;
    if (led !== 16'h0000) begin
      errors++;
      $display("FAIL pre_capture_view: got %h expected 0000", led);
    end
    checks++;
    if (count !== 3'd1) begin
      errors++;
      $display("FAIL count_one: got %0d expected 1", count);
    end
    tick();
    checks++;
    if (led !== 16'hCDEF) begin
      errors++;
      $display("FAIL first_capture_led: got %h expected cdef", led);
    end
    sel_slice = 3'd7;
    tick();
    checks++;
    if (led !== 16'h0123) begin
      errors++;
      $display("FAIL top_slice_led: got %h expected 0123", led);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, mk_word(4'(4'hA + i)), 1'b0);
    checks++;
    if (ovf !== 1'b0 || count !== 3'd4) begin
      errors++;
      $display("FAIL full_no_ovf: got ovf=%b count=%0d expected ovf=0 count=4", ovf, count);
    end
    step(1'b1, mk_word(4'hE), 1'b0);
    checks++;
    if (ovf !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL overflow: got ovf=%b count=%0d expected ovf=1 count=4", ovf, count);
    end
    sel_entry = 2'd3;
    sel_slice = 3'd5;
    tick();
    checks++;
    if (led !== 16'hB005) begin
      errors++;
      $display("FAIL oldest_is_b: got %h expected b005", led);
    end
    sel_entry = 2'd0;
    sel_slice = 3'd2;
    tick();
    checks++;
    if (led !== 16'hE002) begin
      errors++;
      $display("FAIL newest_is_e: got %h expected e002", led);
    end
    step(1'b0, '0, 1'b1);
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", ovf);
    end
    step(1'b1, mk_word(4'hF), 1'b1);
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: got %b expected 1", ovf);
    end
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_empty_read();
    do_reset();
    step(1'b1, mk_word(4'h7), 1'b0);
    sel_entry = 2'd2;
    sel_slice = 3'd3;
    tick();
    tick();
    checks++;
    if (led !== 16'h0000) begin
      errors++;
      $display("FAIL empty_entry: got %h expected 0000", led);
    end
    sel_entry = 2'd0;
    tick();
    checks++;
    if (led !== 16'h7003) begin
      errors++;
      $display("FAIL valid_entry: got %h expected 7003", led);
    end
  endtask

  task automatic test_dump();
    bit started;
    int busy_cycles;
    int nbits;
    logic [127:0] word;
    do_reset();
    step(1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b0);
    run_dump(100, 1'b1, -1, started, busy_cycles, nbits, word);
    checks++;
    if (!started || busy_cycles != DUMP_CYCLES) begin
      errors++;
      $display("FAIL dump_length: got started=%b busy=%0d expected busy=%0d", started, busy_cycles, DUMP_CYCLES);
    end
    checks++;
    if (nbits != 128) begin
      errors++;
      $display("FAIL dump_bits: got %0d expected 128", nbits);
    end
    checks++;
    if (word !== 128'h8000_0000_0000_0000_0000_0000_0000_0001) begin
      errors++;
      $display("FAIL dump_word: got %h expected 80000000000000000000000000000001", word);
    end
    checks++;
    if (count !== 3'(hist.size())) begin
      errors++;
      $display("FAIL capture_during_dump: got count=%0d expected %0d", count, hist.size());
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL no_requeue: got busy=%b expected 0 at cycle %0d", tx_busy, i);
      end
    end
  endtask

  task automatic test_dump_empty();
    bit started;
    int busy_cycles;
    int nbits;
    logic [127:0] word;
    do_reset();
    run_dump(-10, 1'b0, -1, started, busy_cycles, nbits, word);
    checks++;
    if (started !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL dump_empty: got started=%b count=%0d expected 0/0", started, count);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit started;
    int busy_cycles;
    int nbits;
    logic [127:0] word;
    do_reset();
    step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    run_dump(-10, 1'b0, 40, started, busy_cycles, nbits, word);
    checks++;
    if (nbits != 40 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL reach_bit40: got bits=%0d busy=%b expected 40/1", nbits, tx_busy);
    end
    RESET = 1'b0;
    #1;
    checks++;
    if ({tx_clk, tx_data, tx_busy, count, ovf, led} !== 24'h0) begin
      errors++;
      $display("FAIL async_abort: got txc=%b txd=%b busy=%b count=%0d ovf=%b led=%h expected all 0",
               tx_clk, tx_data, tx_busy, count, ovf, led);
    end
    hist.delete();
    m_ovf = 1'b0;
    #2;
    RESET = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (tx_busy !== 1'b0 || tx_clk !== 1'b0) begin
        errors++;
        $display("FAIL no_resume: got busy=%b txc=%b expected 0/0 at cycle %0d", tx_busy, tx_clk, i);
      end
    end
  endtask

  task automatic test_random();
    logic         v;
    logic         clr;
    logic [127:0] d;
    int           se;
    int           ss;
    logic [15:0]  exp_led;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 9) == 0);
      d   = {$urandom, $urandom, $urandom, $urandom};
      se  = $urandom_range(0, 3);
      ss  = $urandom_range(0, 7);
      sel_entry = 2'(se);
      sel_slice = 3'(ss);
      exp_led = m_slice(se, ss);
      step(v, d, clr);
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL rand_led[%0d]: got %h expected %h", n, led, exp_led);
      end
      checks++;
      if (count !== 3'(hist.size())) begin
        errors++;
        $display("FAIL rand_count[%0d]: got %0d expected %0d", n, count, hist.size());
      end
      checks++;
      if (ovf !== m_ovf) begin
        errors++;
        $display("FAIL rand_ovf[%0d]: got %b expected %b", n, ovf, m_ovf);
      end
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_capture_basic();
    test_overflow();
    test_empty_read();
    test_dump();
    test_dump_empty();
    test_reset_mid_dump();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
